mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Arbitrates fetch and data ports onto one single-port memory,
//             with data priority, fetch flush and an access timeout.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        if_flush_i,
    output logic [31:0] if_rdata_o,
    output logic        if_valid_o,
    output logic        if_stall_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic [31:0] d_rdata_o,
    output logic        d_valid_o,
    output logic        d_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        err_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_I = 2'd1,
        S_BUSY_D = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  wait_q;
    logic        flush_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] if_rdata_q;
    logic        if_valid_q;
    logic [31:0] d_rdata_q;
    logic        d_valid_q;
    logic        err_q;

    logic        flush_seen_d;
    logic        timeout_d;

    // A flush arriving in the same cycle as the ack still kills the fetch.
    assign flush_seen_d = flush_q | if_flush_i;
    assign timeout_d    = (wait_q == TMO_LAST) & ~mem_ack_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wait_q      <= 8'd0;
            flush_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            if_rdata_q  <= 32'd0;
            if_valid_q  <= 1'b0;
            d_rdata_q   <= 32'd0;
            d_valid_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    wait_q  <= 8'd0;
                    flush_q <= 1'b0;
                    if (d_req_i) begin
                        state_q     <= S_BUSY_D;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= d_we_i;
                        mem_addr_q  <= d_addr_i;
                        mem_wdata_q <= d_we_i ? d_wdata_i : 32'd0;
                    end else if (if_req_i && !if_flush_i) begin
                        state_q     <= S_BUSY_I;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr_i;
                        mem_wdata_q <= 32'd0;
                    end
                end
                S_BUSY_D: begin
                    if (mem_ack_i || timeout_d) begin
                        state_q     <= S_IDLE;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_wdata_q <= 32'd0;
                        d_valid_q   <= 1'b1;
                        d_rdata_q   <= (mem_ack_i && !mem_we_q) ? mem_rdata_i : 32'd0;
                        if (timeout_d) begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                S_BUSY_I: begin
                    if (mem_ack_i || timeout_d) begin
                        state_q     <= S_IDLE;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_wdata_q <= 32'd0;
                        flush_q     <= 1'b0;
                        if (!flush_seen_d) begin
                            if_valid_q <= 1'b1;
                            if_rdata_q <= mem_ack_i ? mem_rdata_i : NOP_INST;
                        end
                        if (timeout_d) begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        wait_q  <= wait_q + 8'd1;
                        flush_q <= flush_seen_d;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign if_rdata_o  = if_rdata_q;
    assign if_valid_o  = if_valid_q;
    assign if_stall_o  = if_req_i & ~if_valid_q;
    assign d_rdata_o   = d_rdata_q;
    assign d_valid_o   = d_valid_q;
    assign d_stall_o   = d_req_i & ~d_valid_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign err_o       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Scoreboard bench for mem_port_arbiter with a latency-programmable
//             memory model and directed scenarios.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
    logic        if_valid_o, if_stall_o, d_valid_o, d_stall_o;
    logic        mem_req_o, mem_we_o, err_o;
    logic [31:0] mem_rdata;
    logic        model_ack, inj_ack;
    logic        mem_ack;

    assign mem_ack = model_ack | inj_ack;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(16), .NOP_INST(32'h0000_0013)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
        .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o), .if_stall_o(if_stall_o),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_rdata_o(d_rdata_o), .d_valid_o(d_valid_o), .d_stall_o(d_stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
        .err_o(err_o)
    );

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Memory model: ack after 'lat' request cycles (0 = never acknowledges).
    int          lat = 2;
    int          mcnt = 0;
    logic [31:0] mem [logic [31:0]];

    initial begin
        model_ack = 1'b0;
        mem_rdata = 32'd0;
    end

    always @(negedge clk) begin
        if (mem_req_o && lat != 0 && mcnt == lat - 1) begin
            model_ack = 1'b1;
            if (mem_we_o) begin
                mem[mem_addr_o] = mem_wdata_o;
                mem_rdata = 32'hDEAD_BEEF;
            end else begin
                mem_rdata = mem.exists(mem_addr_o) ? mem[mem_addr_o]
                                                   : (mem_addr_o ^ 32'hCAFE_0000);
            end
            mcnt = 0;
        end else begin
            model_ack = 1'b0;
            mcnt = mem_req_o ? mcnt + 1 : 0;
        end
    end

    // Monitor: every completion pulse must match the oldest expected entry.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (if_valid_o) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL if_unexpected actual=%h required=none", if_rdata_o);
            end else begin
                e = exp_q.pop_front();
                chk("if_port_order", {31'd0, e.is_d}, 32'd0);
                chk("if_rdata", if_rdata_o, e.data);
            end
        end
        if (d_valid_o) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL d_unexpected actual=%h required=none", d_rdata_o);
            end else begin
                e = exp_q.pop_front();
                chk("d_port_order", {31'd0, e.is_d}, 32'd1);
                chk("d_rdata", d_rdata_o, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic is_d, input logic [31:0] data);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Waits for the given port's valid pulse, gathering memory-side observations.
    task automatic wait_port(input bit is_d, input int max, output int nreq,
                             output bit stall_ok, output bit saw_we,
                             output logic [31:0] first_addr);
        bit   done;
        logic v, st;
        nreq = 0; stall_ok = 1'b1; saw_we = 1'b0; first_addr = 32'hFFFF_FFFF; done = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (mem_req_o) begin
                if (nreq == 0) first_addr = mem_addr_o;
                nreq++;
            end
            if (mem_we_o) saw_we = 1'b1;
            v  = is_d ? d_valid_o : if_valid_o;
            st = is_d ? d_stall_o : if_stall_o;
            if (st !== !v) stall_ok = 1'b0;
            if (v) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL wait_valid actual=no_pulse required=pulse_within_%0d", max);
        end
    endtask

    int          nreq;
    bit          stall_ok, saw_we;
    logic [31:0] faddr;

    initial begin
        rst = 1'b1; if_req = 0; if_flush = 0; d_req = 0; d_we = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0; inj_ack = 0;
        mem[32'h0000_0008] = 32'h0020_8463;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_mem_wdata", mem_wdata_o, 32'd0);
        chk("rst_valids", {30'd0, if_valid_o, d_valid_o}, 32'd0);
        chk("rst_rdata", if_rdata_o | d_rdata_o, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        @(negedge clk) rst = 1'b0;

        // Plain fetch, ack latency 2
        @(negedge clk);
        if_req = 1; if_addr = 32'h08;
        push(1'b0, 32'h0020_8463);
        wait_port(1'b0, 40, nreq, stall_ok, saw_we, faddr);
        chk("f_mreq_cycles", nreq, 32'd2);
        chk("f_stall", {31'd0, stall_ok}, 32'd1);
        chk("f_we", {31'd0, saw_we}, 32'd0);
        chk("f_addr", faddr, 32'h08);
        @(negedge clk) if_req = 0;

        // Simultaneous store and fetch: store first
        @(negedge clk);
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'd5;
        if_req = 1; if_addr = 32'h20;
        push(1'b1, 32'd0);
        push(1'b0, 32'hCAFE_0020);
        tick();
        chk("prio_mem_we", {31'd0, mem_we_o}, 32'd1);
        chk("prio_mem_addr", mem_addr_o, 32'h40);
        chk("prio_mem_wdata", mem_wdata_o, 32'd5);
        wait_port(1'b1, 40, nreq, stall_ok, saw_we, faddr);
        chk("prio_d_stall", {31'd0, stall_ok}, 32'd1);
        chk("prio_turnaround", {31'd0, mem_req_o}, 32'd0);
        @(negedge clk) d_req = 0;
        tick();
        chk("prio_fetch_issue", {mem_addr_o[30:0], mem_req_o}, {31'h20, 1'b1});
        chk("prio_fetch_we", {31'd0, mem_we_o}, 32'd0);
        wait_port(1'b0, 40, nreq, stall_ok, saw_we, faddr);
        @(negedge clk) if_req = 0;

        // Flush in IDLE blocks issue
        @(negedge clk);
        if_req = 1; if_addr = 32'h30; if_flush = 1;
        tick();
        chk("idle_flush_block", {31'd0, mem_req_o}, 32'd0);

        // Flush one cycle before the ack of an in-flight fetch
        @(negedge clk) begin if_flush = 0; lat = 3; end
        @(negedge clk);
        @(negedge clk) if_flush = 1;
        @(negedge clk) begin if_flush = 0; if_addr = 32'h34; end
        push(1'b0, 32'hCAFE_0034);
        wait_port(1'b0, 40, nreq, stall_ok, saw_we, faddr);
        chk("flush_refetch_cycles", nreq, 32'd3);
        chk("flush_refetch_addr", faddr, 32'h34);
        @(negedge clk) if_req = 0;

        // Load with minimum latency
        @(negedge clk);
        lat = 1; d_req = 1; d_we = 0; d_addr = 32'h10;
        push(1'b1, 32'hCAFE_0010);
        wait_port(1'b1, 40, nreq, stall_ok, saw_we, faddr);
        chk("lat1_mreq_cycles", nreq, 32'd1);
        chk("lat1_err", {31'd0, err_o}, 32'd0);
        @(negedge clk) d_req = 0;

        // Load timeout
        @(negedge clk);
        lat = 0; d_req = 1; d_we = 0; d_addr = 32'h10;
        push(1'b1, 32'd0);
        wait_port(1'b1, 40, nreq, stall_ok, saw_we, faddr);
        chk("tmo_d_mreq_cycles", nreq, 32'd16);
        chk("tmo_d_err", {31'd0, err_o}, 32'd1);
        @(negedge clk) d_req = 0;
        repeat (3) tick();
        chk("tmo_err_sticky", {31'd0, err_o}, 32'd1);

        // Fetch timeout returns NOP
        @(negedge clk);
        if_req = 1; if_addr = 32'h44;
        push(1'b0, 32'h0000_0013);
        wait_port(1'b0, 40, nreq, stall_ok, saw_we, faddr);
        chk("tmo_i_mreq_cycles", nreq, 32'd16);
        @(negedge clk) if_req = 0;

        // Reset during BUSY_D, then a stray ack
        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 32'h50;
        tick();
        tick();
        chk("rstmid_busy", {31'd0, mem_req_o}, 32'd1);
        @(negedge clk) begin rst = 1; d_req = 0; end
        tick();
        chk("rstmid_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rstmid_err", {31'd0, err_o}, 32'd0);
        chk("rstmid_rdata", if_rdata_o | d_rdata_o | mem_addr_o, 32'd0);
        @(negedge clk) begin rst = 0; inj_ack = 1; end
        tick();
        chk("stray_ack_valid", {30'd0, if_valid_o, d_valid_o}, 32'd0);
        chk("stray_ack_req", {31'd0, mem_req_o}, 32'd0);
        @(negedge clk) inj_ack = 0;

        // Normal load after reset returns the earlier store
        @(negedge clk);
        lat = 2; d_req = 1; d_we = 0; d_addr = 32'h40;
        push(1'b1, 32'd5);
        wait_port(1'b1, 40, nreq, stall_ok, saw_we, faddr);
        chk("post_rst_mreq_cycles", nreq, 32'd2);
        @(negedge clk) d_req = 0;

        repeat (3) tick();
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
